gate_length_meter: RTL and testbench
====================================

# gate_length_meter

Measures the duration of each gate interval framed by the one-cycle `pulse_up` / `pulse_dn` edge pulses from the gate edge detector, in the same clock domain. Each completed interval is pushed as a record into a small internal FIFO and drained by the readout logic over a valid/ready handshake. Protocol anomalies and FIFO overflow are counted for status/debug registers.

## Interface
Parameters:
- `CNT_W`, 16: length counter width, in cycles.
- `FIFO_DEPTH`, 4: record FIFO depth; power of two, ≥ 2.

Ports:
- `clk_i`  in  1: clock; the edge detector's output clock.
- `resetn_i`  in  1: asynchronous, active-low reset.
- `pulse_up`  in  1: one-cycle gate-rising pulse.
- `pulse_dn`  in  1: one-cycle gate-falling pulse.
- `m_valid`  out  1: record available.
- `m_ready`  in  1: consumer accepts record.
- `m_data`  out  CNT_W+1: `{sat, length[CNT_W-1:0]}`.
- `gate_open`  out  1: interval currently being timed.
- `drop_cnt`  out  8: records lost to full FIFO; saturating.
- `err_cnt`  out  8: protocol anomalies; saturating.

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, OPEN.
- IDLE, `pulse_up` only: go to OPEN; counter loads 1; `sat` cleared.
- OPEN, no pulse: counter increments. At all-ones it holds and sets `sat`.
- OPEN, `pulse_dn` only: push `{sat, counter}`; go to IDLE.
- OPEN, `pulse_up` only (retrigger): discard the current interval; `err_cnt`+1; counter reloads 1; `sat` cleared; stay OPEN.
- IDLE, `pulse_dn` only (orphan falling edge): `err_cnt`+1; no push.
- `pulse_up` and `pulse_dn` in the same cycle, either state: `err_cnt`+1; go to IDLE; no push.
- `gate_open` is high exactly in OPEN.
- Recorded length = t1 − t0, where t0 is the `pulse_up` cycle and t1 the `pulse_dn` cycle. Minimum recorded value is 1.
- FIFO is show-ahead: `m_data` is valid whenever `m_valid` is high.
- Pop when `m_valid && m_ready`.
- `m_data` holds stable while `m_valid && !m_ready`.
- Push while full:
  - accepted if a pop occurs in the same cycle;
  - otherwise the record is dropped and `drop_cnt`+1.
- Push and pop in the same cycle on a non-full FIFO: both take effect; occupancy unchanged.
- `drop_cnt` and `err_cnt` saturate at 255.

## Timing
- Reset values:
  - state IDLE;
  - `gate_open`=0, `m_valid`=0, `m_data`=0;
  - `drop_cnt`=0, `err_cnt`=0;
  - FIFO empty, counter 0.
- Reset asserted mid-interval: the interval is lost; no record is produced after release.
- `gate_open` rises the cycle after `pulse_up` and falls the cycle after `pulse_dn`.
- Push latency: record visible on `m_valid`/`m_data` the cycle after `pulse_dn` when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- All outputs are registered. No combinational path from `m_ready` to `m_valid`.
- Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit; full/empty come from pointer compare.

## Structure
- Shared package:
  - record field offsets (`SAT_BIT` = CNT_W, length LSB = 0);
  - status counter width (8);
  - FSM state encoding.
- Sub-module `sync_fifo`: single-clock show-ahead FIFO with parameters `WIDTH` and `DEPTH`, ports push/pop/full/empty.
- FSM, counter and status counters stay in the top level.

## Test plan
- `pulse_up` at cycle 10, `pulse_dn` at cycle 15, `m_ready`=1:
  - `m_valid` high at cycle 16 with `m_data` = {0, 5};
  - `gate_open` high in cycles 11–15.
- CNT_W=4, interval of 40 cycles → one record {1, 15}; `err_cnt`=0.
- `m_ready`=0, five complete intervals with FIFO_DEPTH=4:
  - first four records retained, in order;
  - `drop_cnt`=1;
  - then `m_ready`=1 drains exactly four records.
- Sequence `pulse_dn` in IDLE, then `pulse_up`, then `pulse_up` again 3 cycles later, then `pulse_dn` 2 cycles later:
  - `err_cnt`=2;
  - one record of length 2.
- Simultaneous `pulse_up` and `pulse_dn` while OPEN → IDLE, no record, `err_cnt`+1.
- `resetn_i` low for 1 cycle mid-interval with 2 records queued:
  - all outputs at reset values immediately (asynchronous);
  - no record is produced by the following `pulse_dn`.

Source files
------------

// File: rtl/gate_length_meter_pkg.sv
// Shared definitions for the gate length meter: record layout, status counter
// width, FSM encoding and a saturating-increment helper.
package gate_length_meter_pkg;

  localparam int DEF_CNT_W = 16;
  // Record layout: {sat, length}; the sat flag sits just above the length field.
  localparam int SAT_BIT = DEF_CNT_W;
  localparam int LEN_LSB = 0;

  localparam int STAT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_t;

  function automatic int sat_bit(input int cnt_w);
    return cnt_w;
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; head entry is presented on pop_data whenever
// not empty. A push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  // Extra wrap bit distinguishes full (wrap differs) from empty (all equal).
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign pop_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are valid, and empty masks the read port to zero.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gate_length_meter.sv
// Times gate intervals framed by pulse_up/pulse_dn, queues {sat, length}
// records in a show-ahead FIFO and counts protocol errors and drops.
module gate_length_meter
  import gate_length_meter_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              pulse_up,
  input  logic              pulse_dn,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W:0]    m_data,
  output logic              gate_open,
  output logic [STAT_W-1:0] drop_cnt,
  output logic [STAT_W-1:0] err_cnt
);

  localparam int             SAT_IDX = sat_bit(CNT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sat;
  logic [STAT_W-1:0] r_err_cnt;
  logic [STAT_W-1:0] r_drop_cnt;

  logic           w_push;
  logic           w_full;
  logic           w_empty;
  logic           w_drop;
  logic [CNT_W:0] w_rec;

  // A clean falling edge while open closes the interval and emits a record.
  assign w_push = (r_state == ST_OPEN) && pulse_dn && !pulse_up;

  // Full implies non-empty, so a same-cycle pop happens exactly when m_ready.
  assign w_drop = w_push && w_full && !m_ready;

  always_comb begin
    w_rec                   = '0;
    w_rec[SAT_IDX]          = r_sat;
    w_rec[LEN_LSB +: CNT_W] = r_cnt;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pulse_up && !pulse_dn) begin
            r_state <= ST_OPEN;
            r_cnt   <= CNT_ONE;
            r_sat   <= 1'b0;
          end else if (pulse_dn) begin
            // Orphan falling edge, or both edges at once.
            r_err_cnt <= stat_inc(r_err_cnt);
          end
        end
        ST_OPEN: begin
          if (pulse_up && pulse_dn) begin
            r_err_cnt <= stat_inc(r_err_cnt);
            r_state   <= ST_IDLE;
          end else if (pulse_dn) begin
            r_state <= ST_IDLE;
          end else if (pulse_up) begin
            // Retrigger: restart timing from this rising edge.
            r_err_cnt <= stat_inc(r_err_cnt);
            r_cnt     <= CNT_ONE;
            r_sat     <= 1'b0;
          end else if (r_cnt == '1) begin
            r_sat <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= stat_inc(r_drop_cnt);
    end
  end

  sync_fifo #(
    .WIDTH (CNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .push      (w_push),
    .push_data (w_rec),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign m_valid   = !w_empty;
  assign gate_open = (r_state == ST_OPEN);
  assign drop_cnt  = r_drop_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gate_length_meter.sv
// Directed bench for gate_length_meter with CNT_W=4, FIFO_DEPTH=4.
module tb_gate_length_meter;

  localparam int CNT_W      = 4;
  localparam int FIFO_DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             resetn_i;
  logic             pulse_up;
  logic             pulse_dn;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W:0]   m_data;
  logic             gate_open;
  logic [7:0]       drop_cnt;
  logic [7:0]       err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  gate_length_meter #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .pulse_up  (pulse_up),
    .pulse_dn  (pulse_dn),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .gate_open (gate_open),
    .drop_cnt  (drop_cnt),
    .err_cnt   (err_cnt)
  );

  // Advance n clock edges; inputs are driven and outputs sampled 1ns after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Complete interval of length len: pulse_up, len-1 quiet cycles, pulse_dn.
  task automatic interval(input int len);
    pulse_up = 1'b1;
    step(1);
    pulse_up = 1'b0;
    step(len - 1);
    pulse_dn = 1'b1;
    step(1);
    pulse_dn = 1'b0;
  endtask

  task automatic test_reset();
    resetn_i = 1'b0;
    pulse_up = 1'b0;
    pulse_dn = 1'b0;
    m_ready  = 1'b0;
    step(3);
    n_total++;
    if ({gate_open, m_valid, m_data, drop_cnt, err_cnt} !== '0)
      $display("FAIL reset_outputs got go=%0b v=%0b d=%0h drop=%0d err=%0d exp all 0",
               gate_open, m_valid, m_data, drop_cnt, err_cnt);
    else n_pass++;
    resetn_i = 1'b1;
    step(2);
    n_total++;
    if ({gate_open, m_valid} !== 2'b00)
      $display("FAIL reset_release got go=%0b v=%0b exp 0 0", gate_open, m_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    m_ready  = 1'b1;
    pulse_up = 1'b1;              // cycle t0
    step(1);
    pulse_up = 1'b0;
    for (int c = 1; c <= 4; c++) begin  // cycles t0+1 .. t0+4
      n_total++;
      if (gate_open !== 1'b1 || m_valid !== 1'b0)
        $display("FAIL basic_open_c%0d got go=%0b v=%0b exp go=1 v=0", c, gate_open, m_valid);
      else n_pass++;
      step(1);
    end
    pulse_dn = 1'b1;              // cycle t0+5
    n_total++;
    if (gate_open !== 1'b1)
      $display("FAIL basic_open_at_dn got %0b exp 1", gate_open);
    else n_pass++;
    step(1);
    pulse_dn = 1'b0;              // cycle t0+6
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 5'h05 || gate_open !== 1'b0)
      $display("FAIL basic_record got v=%0b d=%0h go=%0b exp v=1 d=05 go=0",
               m_valid, m_data, gate_open);
    else n_pass++;
    step(1);
    n_total++;
    if (m_valid !== 1'b0)
      $display("FAIL basic_popped got v=%0b exp 0", m_valid);
    else n_pass++;
  endtask

  task automatic test_min_length();
    m_ready = 1'b1;
    interval(1);
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 5'h01)
      $display("FAIL min_length got v=%0b d=%0h exp v=1 d=01", m_valid, m_data);
    else n_pass++;
    step(1);
  endtask

  task automatic test_saturation();
    m_ready = 1'b1;
    interval(15);
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 5'h0F)
      $display("FAIL sat_edge15 got v=%0b d=%0h exp v=1 d=0f", m_valid, m_data);
    else n_pass++;
    step(1);
    interval(40);
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 5'h1F || err_cnt !== 8'd0)
      $display("FAIL sat_40 got v=%0b d=%0h err=%0d exp v=1 d=1f err=0",
               m_valid, m_data, err_cnt);
    else n_pass++;
    step(1);
    n_total++;
    if (m_valid !== 1'b0)
      $display("FAIL sat_single_record got v=%0b exp 0", m_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int len = 1; len <= 5; len++) interval(len);
    n_total++;
    if (drop_cnt !== 8'd1 || m_valid !== 1'b1)
      $display("FAIL ovf_drop got drop=%0d v=%0b exp drop=1 v=1", drop_cnt, m_valid);
    else n_pass++;
    step(2);
    n_total++;
    if (m_data !== 5'h01)
      $display("FAIL ovf_hold got d=%0h exp 01", m_data);
    else n_pass++;
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_total++;
      if (m_valid !== 1'b1 || m_data !== 5'(i))
        $display("FAIL ovf_drain%0d got v=%0b d=%0h exp v=1 d=%0h", i, m_valid, m_data, i);
      else n_pass++;
      step(1);
    end
    n_total++;
    if (m_valid !== 1'b0)
      $display("FAIL ovf_empty got v=%0b exp 0", m_valid);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    // Full FIFO with pop in the push cycle: no drop, new record lands at tail.
    m_ready = 1'b0;
    for (int len = 1; len <= 4; len++) interval(len);
    pulse_up = 1'b1;
    step(1);
    pulse_up = 1'b0;
    step(5);
    pulse_dn = 1'b1;
    m_ready  = 1'b1;
    step(1);
    pulse_dn = 1'b0;
    n_total++;
    if (drop_cnt !== 8'd1 || m_data !== 5'h02)
      $display("FAIL fullpp got drop=%0d d=%0h exp drop=1 d=02", drop_cnt, m_data);
    else n_pass++;
    step(3);
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 5'h06)
      $display("FAIL fullpp_tail got v=%0b d=%0h exp v=1 d=06", m_valid, m_data);
    else n_pass++;
    step(1);
  endtask

  task automatic test_errors();
    m_ready  = 1'b1;
    pulse_dn = 1'b1;     // orphan in IDLE
    step(1);
    pulse_dn = 1'b0;
    n_total++;
    if (err_cnt !== 8'd1 || m_valid !== 1'b0)
      $display("FAIL err_orphan got err=%0d v=%0b exp err=1 v=0", err_cnt, m_valid);
    else n_pass++;
    step(1);
    pulse_up = 1'b1;
    step(1);
    pulse_up = 1'b0;
    step(2);
    pulse_up = 1'b1;     // retrigger 3 cycles after first pulse_up
    step(1);
    pulse_up = 1'b0;
    step(1);
    pulse_dn = 1'b1;     // 2 cycles after retrigger
    step(1);
    pulse_dn = 1'b0;
    n_total++;
    if (err_cnt !== 8'd2 || m_valid !== 1'b1 || m_data !== 5'h02)
      $display("FAIL err_retrigger got err=%0d v=%0b d=%0h exp err=2 v=1 d=02",
               err_cnt, m_valid, m_data);
    else n_pass++;
    step(1);
    n_total++;
    if (m_valid !== 1'b0)
      $display("FAIL err_one_record got v=%0b exp 0", m_valid);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    m_ready  = 1'b1;
    pulse_up = 1'b1;
    step(1);
    pulse_up = 1'b0;
    step(2);
    pulse_up = 1'b1;
    pulse_dn = 1'b1;
    step(1);
    pulse_up = 1'b0;
    pulse_dn = 1'b0;
    n_total++;
    if (gate_open !== 1'b0 || m_valid !== 1'b0 || err_cnt !== 8'd3)
      $display("FAIL simul got go=%0b v=%0b err=%0d exp go=0 v=0 err=3",
               gate_open, m_valid, err_cnt);
    else n_pass++;
    step(2);
    n_total++;
    if (m_valid !== 1'b0)
      $display("FAIL simul_norecord got v=%0b exp 0", m_valid);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    interval(3);
    interval(4);
    pulse_up = 1'b1;
    step(1);
    pulse_up = 1'b0;
    step(1);
    n_total++;
    if (m_valid !== 1'b1 || m_data !== 5'h03 || gate_open !== 1'b1)
      $display("FAIL rst_pre got v=%0b d=%0h go=%0b exp v=1 d=03 go=1",
               m_valid, m_data, gate_open);
    else n_pass++;
    #2 resetn_i = 1'b0;
    #1;
    n_total++;
    if ({gate_open, m_valid, m_data, drop_cnt, err_cnt} !== '0)
      $display("FAIL rst_async got go=%0b v=%0b d=%0h drop=%0d err=%0d exp all 0",
               gate_open, m_valid, m_data, drop_cnt, err_cnt);
    else n_pass++;
    @(posedge clk_i);
    #1 resetn_i = 1'b1;
    step(2);
    pulse_dn = 1'b1;
    step(1);
    pulse_dn = 1'b0;
    n_total++;
    if (m_valid !== 1'b0 || err_cnt !== 8'd1 || gate_open !== 1'b0)
      $display("FAIL rst_lost got v=%0b err=%0d go=%0b exp v=0 err=1 go=0",
               m_valid, err_cnt, gate_open);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_length();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_errors();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
